stream_fifo: RTL and testbench

//  Parametrised synchronous FIFO with valid/ready handshakes on both sides.

---
 rtl/stream_fifo_pkg.sv | 27 ++
 rtl/stream_fifo_ptr.sv | 25 ++
 rtl/stream_fifo.sv | 138 +++++++++++++
 tb/tb_stream_fifo.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_fifo_pkg.sv
// Shared types and sizing helpers for stream_fifo and its pointer sub-module.
package stream_fifo_pkg;

  typedef enum logic [1:0] {
    FIFO_EMPTY   = 2'd0,
    FIFO_PARTIAL = 2'd1,
    FIFO_FULL    = 2'd2
  } fifo_state_e;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return ($clog2(depth) < 1) ? 1 : $clog2(depth);
  endfunction

  function automatic fifo_state_e fifo_state(input int cnt, input int depth);
    if (cnt == 0)
      return FIFO_EMPTY;
    else if (cnt >= depth)
      return FIFO_FULL;
    else
      return FIFO_PARTIAL;
  endfunction

endpackage

// File: rtl/stream_fifo_ptr.sv
// Modulo-DEPTH wrap counter for FIFO read/write pointers; clr wins over inc.
// Latency: new value visible the cycle after inc/clr; no backpressure of its own.
module stream_fifo_ptr #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= '0;
    else if (clr)
      ptr <= '0;
    else if (inc)
      ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
  end

endmodule

// File: rtl/stream_fifo.sv
// Any-depth valid/ready FIFO with flush, occupancy and threshold flags; 1-cycle write-to-read, in_ready low when full.
// Optional high-water statistic enabled by STREAM_FIFO_STATS_EN.
module stream_fifo
  import stream_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 2,
  localparam int CNT_W     = cnt_width(DEPTH),
  localparam int PTR_W     = ptr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]      count,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CNT_W-1:0]      high_water
);

  if (DEPTH < 2) begin : g_bad_depth
    $error("stream_fifo: DEPTH must be >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("stream_fifo: AF_LEVEL must be in 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("stream_fifo: AE_LEVEL must be in 0..DEPTH-1");
  end

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count_next;
  logic                  push;
  logic                  pop;

  // Handshake readiness depends only on registered count, so no combinational
  // path from out_ready to in_ready: a pop while full cannot admit a push.
  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);

  stream_fifo_ptr #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (push),
    .ptr   (wr_ptr)
  );

  stream_fifo_ptr #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (pop),
    .ptr   (rd_ptr)
  );

  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count + 1'b1;
        2'b01:   count_next = count - 1'b1;
        default: count_next = count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else
      count <= count_next;
  end

  // Storage is deliberately unreset; a flushed push must not land in memory.
  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[wr_ptr] <= in_data;
  end

  assign out_data = mem[rd_ptr];

`ifdef STREAM_FIFO_STATS_EN
  logic [CNT_W-1:0] high_water_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      high_water_q <= '0;
    else if (flush)
      high_water_q <= '0;
    else if (count_next > high_water_q)
      high_water_q <= count_next;
  end

  assign high_water = high_water_q;
`else
  assign high_water = '0;
`endif

`ifndef SYNTHESIS
  fifo_state_e state;
  assign state = fifo_state(int'(count), DEPTH);

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    count <= FULL_CNT);
  a_full_blocks: assert property (@(posedge clk) disable iff (!rst_n)
    (state == FIFO_FULL) |-> !in_ready);
  a_empty_idle: assert property (@(posedge clk) disable iff (!rst_n)
    (state == FIFO_EMPTY) |-> !out_valid);
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// Directed self-checking bench for stream_fifo (DEPTH=16 and DEPTH=5 instances).
module tb_stream_fifo;
    import stream_fifo_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        flush, in_valid, in_ready, out_valid, out_ready, almost_full, almost_empty;
    logic [31:0] in_data, out_data;
    logic [4:0]  count, high_water;

    logic        f5_flush, f5_in_valid, f5_in_ready, f5_out_valid, f5_out_ready, f5_af, f5_ae;
    logic [7:0]  f5_in_data, f5_out_data;
    logic [2:0]  f5_count, f5_hw;

    int n_tests = 0;
    int n_fail  = 0;
    bit done    = 1'b0;

    stream_fifo #(
        .DATA_WIDTH (32),
        .DEPTH      (16),
        .AF_LEVEL   (12),
        .AE_LEVEL   (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .high_water   (high_water)
    );

    stream_fifo #(
        .DATA_WIDTH (8),
        .DEPTH      (5),
        .AF_LEVEL   (4),
        .AE_LEVEL   (1)
    ) dut5 (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (f5_flush),
        .in_valid     (f5_in_valid),
        .in_ready     (f5_in_ready),
        .in_data      (f5_in_data),
        .out_valid    (f5_out_valid),
        .out_ready    (f5_out_ready),
        .out_data     (f5_out_data),
        .count        (f5_count),
        .almost_full  (f5_af),
        .almost_empty (f5_ae),
        .high_water   (f5_hw)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input int n, input logic [31:0] base);
        in_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            in_data = base + 32'(i);
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        if (!done) begin
            n_fail++;
            $error("FAIL timeout: bench did not complete within the wait limit");
        end
        $finish;
    end

    initial begin
        rst_n = 1'b0;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        f5_flush = 1'b0; f5_in_valid = 1'b0; f5_out_ready = 1'b0; f5_in_data = '0;
        #12;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || almost_empty !== 1'b1 ||
            almost_full !== 1'b0 || count !== 5'd0) begin
            n_fail++;
            $error("FAIL rst_state in_ready=%0b out_valid=%0b ae=%0b af=%0b count=%0d",
                   in_ready, out_valid, almost_empty, almost_full, count);
        end
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $error("FAIL rst_in_ready %0b", in_ready); end
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $error("FAIL rst_out_valid %0b", out_valid); end
        n_tests++;
        if (almost_empty !== 1'b1) begin n_fail++; $error("FAIL rst_almost_empty %0b", almost_empty); end
        n_tests++;
        if (almost_full !== 1'b0) begin n_fail++; $error("FAIL rst_almost_full %0b", almost_full); end
        n_tests++;
        if (count !== 5'd0) begin n_fail++; $error("FAIL rst_count %0d", count); end
        n_tests++;
        if (high_water !== 5'd0) begin n_fail++; $error("FAIL rst_high_water %0d", high_water); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = 32'hA0 + 32'(i);
            tick();
            n_tests++;
            if (count !== 5'(i + 1)) begin
                n_fail++; $error("FAIL fill_count i=%0d observed=%0d", i, count);
            end
            n_tests++;
            if (almost_full !== 1'(i + 1 >= 12)) begin
                n_fail++; $error("FAIL fill_af i=%0d observed=%0b", i, almost_full);
            end
        end
        n_tests++;
        if (in_ready !== 1'b0) begin n_fail++; $error("FAIL full_in_ready %0b", in_ready); end
        in_data = 32'hDEAD;
        tick();
        n_tests++;
        if (count !== 5'd16) begin n_fail++; $error("FAIL full_reject_count %0d", count); end
        in_valid = 1'b0;

        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_tests++;
            if (out_data !== 32'hA0 + 32'(i)) begin
                n_fail++; $error("FAIL full_drain_data i=%0d observed=%0h", i, out_data);
            end
            tick();
        end
        out_ready = 1'b0;
        n_tests++;
        if (count !== 5'd0) begin n_fail++; $error("FAIL full_drain_count %0d", count); end
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $error("FAIL full_drain_valid %0b", out_valid); end

        push_n(5, 32'h11);
        n_tests++;
        if (count !== 5'd5) begin n_fail++; $error("FAIL drain_count5 %0d", count); end
        n_tests++;
        if (almost_empty !== 1'b0) begin n_fail++; $error("FAIL drain_ae_at5 %0b", almost_empty); end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (out_valid !== 1'b1) begin
                n_fail++; $error("FAIL drain_valid i=%0d", i);
            end
            n_tests++;
            if (out_data !== 32'h11 + 32'(i)) begin
                n_fail++; $error("FAIL drain_data i=%0d observed=%0h", i, out_data);
            end
            n_tests++;
            if (almost_empty !== 1'(5 - i <= 2)) begin
                n_fail++; $error("FAIL drain_ae i=%0d observed=%0b", i, almost_empty);
            end
            tick();
        end
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $error("FAIL drain_valid_end %0b", out_valid); end
        n_tests++;
        if (almost_empty !== 1'b1) begin n_fail++; $error("FAIL drain_ae_end %0b", almost_empty); end

        f5_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            f5_in_data = 8'(1 + i);
            tick();
        end
        n_tests++;
        if (f5_count !== 3'd3) begin n_fail++; $error("FAIL wrap_prefill_count %0d", f5_count); end
        f5_out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            f5_in_data = 8'(4 + i);
            n_tests++;
            if (f5_out_data !== 8'(1 + i)) begin
                n_fail++; $error("FAIL wrap_pair_data i=%0d observed=%0h", i, f5_out_data);
            end
            tick();
            n_tests++;
            if (f5_count !== 3'd3) begin
                n_fail++; $error("FAIL wrap_pair_count i=%0d observed=%0d", i, f5_count);
            end
        end
        f5_in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (f5_out_data !== 8'(13 + i)) begin
                n_fail++; $error("FAIL wrap_tail_data i=%0d observed=%0h", i, f5_out_data);
            end
            tick();
        end
        f5_out_ready = 1'b0;
        n_tests++;
        if (f5_out_valid !== 1'b0) begin n_fail++; $error("FAIL wrap_empty %0b", f5_out_valid); end

        push_n(7, 32'h70);
        n_tests++;
        if (count !== 5'd7) begin n_fail++; $error("FAIL flush_pre_count %0d", count); end
        flush = 1'b1; in_valid = 1'b1; in_data = 32'hBAD;
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $error("FAIL flush_in_ready %0b", in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_tests++;
        if (count !== 5'd0) begin n_fail++; $error("FAIL flush_count %0d", count); end
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $error("FAIL flush_out_valid %0b", out_valid); end
        push_n(1, 32'h99);
        n_tests++;
        if (out_data !== 32'h99) begin n_fail++; $error("FAIL flush_next_data %0h", out_data); end
        n_tests++;
        if (count !== 5'd1) begin n_fail++; $error("FAIL flush_next_count %0d", count); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        push_n(9, 32'h200);
        n_tests++;
        if (count !== 5'd9) begin n_fail++; $error("FAIL arst_pre_count %0d", count); end
        in_valid = 1'b1; in_data = 32'h300;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (count !== 5'd0) begin n_fail++; $error("FAIL arst_count %0d", count); end
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $error("FAIL arst_out_valid %0b", out_valid); end
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $error("FAIL arst_in_ready %0b", in_ready); end
        n_tests++;
        if (almost_empty !== 1'b1) begin n_fail++; $error("FAIL arst_ae %0b", almost_empty); end
        n_tests++;
        if (almost_full !== 1'b0) begin n_fail++; $error("FAIL arst_af %0b", almost_full); end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_tests++;
        if (count !== 5'd0) begin n_fail++; $error("FAIL arst_after_count %0d", count); end

        push_n(10, 32'h400);
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        out_ready = 1'b0;
        n_tests++;
        if (count !== 5'd1) begin n_fail++; $error("FAIL hw_count %0d", count); end
`ifdef STREAM_FIFO_STATS_EN
        n_tests++;
        if (high_water !== 5'd10) begin n_fail++; $error("FAIL hw_peak %0d", high_water); end
`else
        n_tests++;
        if (high_water !== 5'd0) begin n_fail++; $error("FAIL hw_peak %0d", high_water); end
`endif
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_tests++;
        if (high_water !== 5'd0) begin n_fail++; $error("FAIL hw_flush %0d", high_water); end
        n_tests++;
        if (count !== 5'd0) begin n_fail++; $error("FAIL hw_flush_count %0d", count); end

        done = 1'b1;
        if (n_fail != 0)
            $error("FAIL %0d of %0d checks failed", n_fail, n_tests);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
